csr_timer: RTL

Constant-timer and stable-counter unit for the LoongArch CSR file. Owns TID, TCFG, TVAL and TICLR plus the 64-bit stable counter read by rdcntvl.w/rdcntvh.w/rdcntid. It sits directly upstream of the exception CSR block: its `timer_int` feeds ESTAT.IS[11], and its CSR read data is OR-merged into the CSR read path.

---
 rtl/csr_timer_pkg.sv | 18 +
 rtl/csr_timer_stable_counter.sv | 16 +
 rtl/csr_timer.sv | 71 +++++++
 3 files changed

// File: rtl/csr_timer_pkg.sv
// csr_timer_pkg: CSR numbers, field positions and masked-write helper for the timer CSRs
package csr_timer_pkg;
   localparam logic [13:0] CSR_TID   = 14'h40;
   localparam logic [13:0] CSR_TCFG  = 14'h41;
   localparam logic [13:0] CSR_TVAL  = 14'h42;
   localparam logic [13:0] CSR_TICLR = 14'h44;
   localparam int CSR_TCFG_EN       = 0;
   localparam int CSR_TCFG_PERIOD   = 1;
   localparam int CSR_TCFG_INITV_LO = 2;
   localparam int CSR_TCFG_INITV_HI = 31;
   localparam int CSR_TICLR_CLR     = 0;
   localparam int CSR_TID_TID_LO    = 0;
   localparam int CSR_TID_TID_HI    = 31;

   function automatic logic [31:0] wmerge(input logic [31:0] m, input logic [31:0] d, input logic [31:0] o);
      return (m & d) | (~m & o);
   endfunction
endpackage

// File: rtl/csr_timer_stable_counter.sv
// stable_counter: free-running 64-bit counter behind rdcntvl.w/rdcntvh.w
module stable_counter (
   input  logic        clk,
   input  logic        reset,
   output logic [63:0] cnt
);
   logic [63:0] cnt_q;

   // count every cycle, wrapping naturally at 2^64
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_q + 64'd1;
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/csr_timer.sv
// csr_timer: TID/TCFG/TVAL/TICLR CSRs, constant timer interrupt and stable counter
module csr_timer
   import csr_timer_pkg::*;
#(
   parameter logic [31:0] CORE_ID = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        csr_re,
   input  logic [13:0] csr_num,
   input  logic        csr_we,
   input  logic [31:0] csr_wmask,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic        csr_hit,
   output logic        timer_int,
   output logic [63:0] stable_cnt,
   output logic [31:0] tid
);
   logic [31:0] tid_q, tid_d, tcfg_q, tcfg_d, tval_q, tval_d, tcfg_new;
   logic        ti_q, ti_d, tcfg_we, ti_clr, ti_set;

   stable_counter u_stable_counter (
      .clk   (clk),
      .reset (reset),
      .cnt   (stable_cnt)
   );

   // next-state: a TCFG write enabling the timer reloads first, otherwise count down and stop at all-ones
   always_comb begin
      tcfg_new = wmerge(csr_wmask, csr_wdata, tcfg_q);
      tcfg_we  = csr_we && csr_num == CSR_TCFG;
      tid_d    = (csr_we && csr_num == CSR_TID) ? wmerge(csr_wmask, csr_wdata, tid_q) : tid_q;
      tcfg_d   = tcfg_we ? tcfg_new : tcfg_q;
      tval_d   = (tcfg_we && tcfg_new[CSR_TCFG_EN]) ? {tcfg_new[CSR_TCFG_INITV_HI:CSR_TCFG_INITV_LO], 2'b00} :
                 (tcfg_q[CSR_TCFG_EN] && tval_q != '1) ?
                    ((tval_q == '0 && tcfg_q[CSR_TCFG_PERIOD]) ? {tcfg_q[CSR_TCFG_INITV_HI:CSR_TCFG_INITV_LO], 2'b00}
                                                                : tval_q - 32'd1) :
                 tval_q;
      ti_set   = tcfg_q[CSR_TCFG_EN] && tval_q == '0;
      ti_clr   = csr_we && csr_num == CSR_TICLR && csr_wmask[CSR_TICLR_CLR] && csr_wdata[CSR_TICLR_CLR];
      ti_d     = ti_set | (ti_q & ~ti_clr);
   end

   // CSR state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         tid_q  <= CORE_ID;
         tcfg_q <= '0;
         tval_q <= '1;
         ti_q   <= 1'b0;
      end else begin
         tid_q  <= tid_d;
         tcfg_q <= tcfg_d;
         tval_q <= tval_d;
         ti_q   <= ti_d;
      end
   end

   // combinational read port; TICLR is write-only and reads as zero
   always_comb begin
      csr_hit   = csr_num == CSR_TID || csr_num == CSR_TCFG || csr_num == CSR_TVAL || csr_num == CSR_TICLR;
      csr_rdata = !csr_re                ? 32'd0 :
                  csr_num == CSR_TID      ? tid_q[CSR_TID_TID_HI:CSR_TID_TID_LO] :
                  csr_num == CSR_TCFG     ? tcfg_q :
                  csr_num == CSR_TVAL     ? tval_q : 32'd0;
   end

   assign timer_int = ti_q;
   assign tid       = tid_q;
endmodule
